// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch / data) arbiter in front of a single-ported RAM
//            with a four-phase memFuncActive / memFuncComplete handshake.
//            A tie goes to the port that was not granted last. Misaligned or
//            reserved-size requests are granted but answered with Err instead
//            of a RAM access.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk, nReset                      clock, asynchronous active-low reset
//   fReq, fAddr                      fetch request, byte address (word read)
//   fDone, fErr, fData               fetch completion pulse, error, read data
//   dReq, dReadWrite, dAddr          data request, 1=write 0=read, address
//   dDataIn, dDataSize               write data, size (00 B, 01 H, 11 W)
//   dDone, dErr, dData               data completion pulse, error, read data
//   memFuncActive, readWrite,
//   address, dataIn, dataSize        RAM-side request bus
//   dataOut, memFuncComplete         RAM read data and completion
// Configuration
//   MEM_ARBITER_TIMEOUT_EN           when defined, an access that takes
//                                    TIMEOUT_CYCLES cycles is aborted with Err
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        fReq,
    input  logic [8:0]  fAddr,
    output logic        fDone,
    output logic        fErr,
    output logic [31:0] fData,
    input  logic        dReq,
    input  logic        dReadWrite,
    input  logic [8:0]  dAddr,
    input  logic [31:0] dDataIn,
    input  logic [1:0]  dDataSize,
    output logic        dDone,
    output logic        dErr,
    output logic [31:0] dData,
    output logic        memFuncActive,
    output logic        readWrite,
    output logic [8:0]  address,
    output logic [31:0] dataIn,
    output logic [1:0]  dataSize,
    input  logic [31:0] dataOut,
    input  logic        memFuncComplete
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACCESS  = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    localparam logic [1:0] c_SIZE_WORD = 2'b11;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeoutRange
        $error("mem_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [1:0]  r_state;
    logic        r_lastGrantData;   // 1: data port won the last grant
    logic        r_winnerData;      // port owning the transfer in flight
    logic        r_errPending;      // grant was a rejected (misaligned) request
    logic        r_memFuncActive;
    logic        r_readWrite;
    logic [8:0]  r_address;
    logic [31:0] r_dataIn;
    logic [1:0]  r_dataSize;
    logic        r_fDone, r_fErr, r_dDone, r_dErr;
    logic [31:0] r_fData, r_dData;

    logic        w_anyReq;
    logic        w_grantData;
    logic        w_reqWrite;
    logic [8:0]  w_reqAddr;
    logic [31:0] w_reqData;
    logic [1:0]  w_reqSize;
    logic        w_reqBad;
    logic        w_timeout;
    logic        w_releaseErr;

    // Arbitration and alignment check of the would-be winner.
    always_comb begin
        w_anyReq    = fReq | dReq;
        w_grantData = dReq & (~fReq | ~r_lastGrantData);
        if (w_grantData) begin
            w_reqWrite = dReadWrite;
            w_reqAddr  = dAddr;
            w_reqData  = dDataIn;
            w_reqSize  = dDataSize;
        end else begin
            w_reqWrite = 1'b0;
            w_reqAddr  = fAddr;
            w_reqData  = '0;
            w_reqSize  = c_SIZE_WORD;
        end
        case (w_reqSize)
            2'b00:   w_reqBad = 1'b0;
            2'b01:   w_reqBad = w_reqAddr[0];
            2'b11:   w_reqBad = |w_reqAddr[1:0];
            default: w_reqBad = 1'b1;
        endcase
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [7:0] r_toCnt;

    // Counts edges since grant; cleared whenever the arbiter is idle.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_toCnt <= '0;
        end else if (r_state == c_IDLE) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + 8'd1;
        end
    end

    assign w_timeout = (r_state != c_IDLE) && (r_toCnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Leaving RELEASE with memFuncComplete still high only happens on timeout.
    assign w_releaseErr = r_errPending | memFuncComplete;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state         <= c_IDLE;
            r_lastGrantData <= 1'b0;
            r_winnerData    <= 1'b0;
            r_errPending    <= 1'b0;
            r_memFuncActive <= 1'b0;
            r_readWrite     <= 1'b0;
            r_address       <= '0;
            r_dataIn        <= '0;
            r_dataSize      <= '0;
            r_fDone         <= 1'b0;
            r_fErr          <= 1'b0;
            r_dDone         <= 1'b0;
            r_dErr          <= 1'b0;
            r_fData         <= '0;
            r_dData         <= '0;
        end else begin
            r_fDone <= 1'b0;
            r_fErr  <= 1'b0;
            r_dDone <= 1'b0;
            r_dErr  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_anyReq) begin
                        r_lastGrantData <= w_grantData;
                        r_winnerData    <= w_grantData;
                        r_errPending    <= w_reqBad;
                        if (w_reqBad) begin
                            // No RAM access: RELEASE answers with Err next edge.
                            r_state <= c_RELEASE;
                        end else begin
                            r_memFuncActive <= 1'b1;
                            r_readWrite     <= w_reqWrite;
                            r_address       <= w_reqAddr;
                            r_dataIn        <= w_reqData;
                            r_dataSize      <= w_reqSize;
                            r_state         <= c_ACCESS;
                        end
                    end
                end
                c_ACCESS: begin
                    if (memFuncComplete) begin
                        r_memFuncActive <= 1'b0;
                        if (!r_readWrite) begin
                            if (r_winnerData) begin
                                r_dData <= dataOut;
                            end else begin
                                r_fData <= dataOut;
                            end
                        end
                        r_state <= c_RELEASE;
                    end else if (w_timeout) begin
                        r_memFuncActive <= 1'b0;
                        r_dDone         <= r_winnerData;
                        r_dErr          <= r_winnerData;
                        r_fDone         <= ~r_winnerData;
                        r_fErr          <= ~r_winnerData;
                        r_state         <= c_IDLE;
                    end
                end
                c_RELEASE: begin
                    if (r_errPending || !memFuncComplete || w_timeout) begin
                        r_dDone <= r_winnerData;
                        r_dErr  <= r_winnerData & w_releaseErr;
                        r_fDone <= ~r_winnerData;
                        r_fErr  <= ~r_winnerData & w_releaseErr;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign fDone         = r_fDone;
    assign fErr          = r_fErr;
    assign fData         = r_fData;
    assign dDone         = r_dDone;
    assign dErr          = r_dErr;
    assign dData         = r_dData;
    assign memFuncActive = r_memFuncActive;
    assign readWrite     = r_readWrite;
    assign address       = r_address;
    assign dataIn        = r_dataIn;
    assign dataSize      = r_dataSize;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A behavioural RAM answers
//            the handshake; a transaction-level reference model predicts the
//            grant order, error flags, RAM bus contents and read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        fReq = 1'b0;
    logic [8:0]  fAddr = '0;
    logic        fDone, fErr;
    logic [31:0] fData;
    logic        dReq = 1'b0;
    logic        dReadWrite = 1'b0;
    logic [8:0]  dAddr = '0;
    logic [31:0] dDataIn = '0;
    logic [1:0]  dDataSize = '0;
    logic        dDone, dErr;
    logic [31:0] dData;
    logic        memFuncActive, readWrite;
    logic [8:0]  address;
    logic [31:0] dataIn;
    logic [1:0]  dataSize;
    logic [31:0] dataOut = '0;
    logic        memFuncComplete = 1'b0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .nReset(nReset),
        .fReq(fReq), .fAddr(fAddr), .fDone(fDone), .fErr(fErr), .fData(fData),
        .dReq(dReq), .dReadWrite(dReadWrite), .dAddr(dAddr), .dDataIn(dDataIn),
        .dDataSize(dDataSize), .dDone(dDone), .dErr(dErr), .dData(dData),
        .memFuncActive(memFuncActive), .readWrite(readWrite), .address(address),
        .dataIn(dataIn), .dataSize(dataSize), .dataOut(dataOut),
        .memFuncComplete(memFuncComplete)
    );

    always #5 Clk = ~Clk;

    int nTests = 0;
    int nFail  = 0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          isData;
        bit          wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          bad;
        logic [31:0] rdata;
    } txn_t;

    txn_t        expQ[$];
    logic [7:0]  ramMem [512];
    logic [7:0]  refMem [512];
    bit          refLastData;
    logic [31:0] refF, refD;

    function automatic int sizeBytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] refWord(input logic [8:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = refMem[(int'(a) + i) % 512];
        return w;
    endfunction

    task automatic modelQueue(input txn_t t);
        txn_t u;
        int   n;
        u = t;
        n = sizeBytes(t.size);
        if (n == 0) u.bad = 1'b1;
        else        u.bad = (int'(t.addr) % n) != 0;
        u.rdata = '0;
        if (!u.bad) begin
            if (u.wr) begin
                for (int i = 0; i < n; i++) refMem[(int'(u.addr) + i) % 512] = u.wdata[8*i +: 8];
            end else begin
                u.rdata = refWord(u.addr);
            end
        end
        refLastData = u.isData;
        expQ.push_back(u);
    endtask

    // ---------------- behavioural RAM ----------------
    int ramDelay = 2;
    bit ramHang  = 1'b0;
    int ramState = 0;
    int ramCnt   = 0;

    task automatic ramOp();
        int n;
        n = sizeBytes(dataSize);
        if (readWrite) begin
            for (int i = 0; i < n; i++) ramMem[(int'(address) + i) % 512] = dataIn[8*i +: 8];
        end else begin
            for (int i = 0; i < 4; i++) dataOut[8*i +: 8] = ramMem[(int'(address) + i) % 512];
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (!nReset) begin
                memFuncComplete = 1'b0;
                ramState = 0;
            end else if (ramState == 0) begin
                if (memFuncActive) begin
                    ramCnt = ramDelay;
                    ramState = 1;
                end
            end else if (ramState == 1) begin
                if (!memFuncActive) begin
                    ramState = 0;
                end else if (!ramHang) begin
                    if (ramCnt == 0) begin
                        ramOp();
                        memFuncComplete = 1'b1;
                        ramState = 2;
                    end else begin
                        ramCnt--;
                    end
                end
            end else begin
                if (!memFuncActive) begin
                    memFuncComplete = 1'b0;
                    ramState = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit          monOn  = 1'b0;
    bit          prevAct = 1'b0, prevF = 1'b0, prevD = 1'b0, sawAct = 1'b0;
    logic [11:0] busSnap = '0;

    initial begin
        txn_t t;
        forever begin
            @(negedge Clk);
            if (monOn) begin
                checkValue("errWithoutDone", {30'b0, fErr & ~fDone, dErr & ~dDone}, 32'd0);
                checkValue("doneSingleCycle", {30'b0, fDone & prevF, dDone & prevD}, 32'd0);
                if (memFuncActive && !prevAct) begin
                    busSnap = {address, dataSize, readWrite};
                    if (expQ.size() == 0) begin
                        checkValue("accessUnexpected", {31'b0, memFuncActive}, 32'd0);
                    end else begin
                        t = expQ[0];
                        sawAct = 1'b1;
                        checkValue("accessForBadReq", {31'b0, t.bad}, 32'd0);
                        checkValue("busReadWrite", {31'b0, readWrite}, {31'b0, t.wr});
                        checkValue("busAddress", {23'b0, address}, {23'b0, t.addr});
                        checkValue("busSize", {30'b0, dataSize}, {30'b0, t.size});
                        if (t.wr) checkValue("busDataIn", dataIn, t.wdata);
                    end
                end else if (memFuncActive) begin
                    checkValue("busStable", {20'b0, address, dataSize, readWrite}, {20'b0, busSnap});
                end
                if (fDone || dDone) begin
                    if (expQ.size() == 0) begin
                        checkValue("doneUnexpected", {30'b0, fDone, dDone}, 32'd0);
                    end else begin
                        t = expQ.pop_front();
                        checkValue("donePort", {30'b0, fDone, dDone}, t.isData ? 32'd1 : 32'd2);
                        checkValue("doneErr", {31'b0, fErr | dErr}, {31'b0, t.bad});
                        checkValue("ramAccessIssued", {31'b0, sawAct}, {31'b0, ~t.bad});
                        if (!t.bad && !t.wr) begin
                            if (t.isData) refD = t.rdata;
                            else          refF = t.rdata;
                        end
                        checkValue("fData", fData, refF);
                        checkValue("dData", dData, refD);
                    end
                    sawAct = 1'b0;
                end
            end
            prevAct = memFuncActive;
            prevF   = fDone;
            prevD   = dDone;
        end
    end

    // ---------------- stimulus ----------------
    task automatic runRound(input bit fOn, input logic [8:0] fA, input bit dOn, input bit dWr,
                            input logic [8:0] dA, input logic [31:0] dD, input logic [1:0] dSz,
                            output int lat);
        txn_t ft, dt;
        bit   dataFirst;
        int   k;
        ft.isData = 1'b0; ft.wr = 1'b0; ft.addr = fA; ft.wdata = '0;
        ft.size = 2'b11;  ft.bad = 1'b0; ft.rdata = '0;
        dt.isData = 1'b1; dt.wr = dWr; dt.addr = dA; dt.wdata = dD;
        dt.size = dSz;    dt.bad = 1'b0; dt.rdata = '0;
        dataFirst = dOn && (!fOn || !refLastData);
        if (dataFirst) begin
            modelQueue(dt);
            if (fOn) modelQueue(ft);
        end else begin
            if (fOn) modelQueue(ft);
            if (dOn) modelQueue(dt);
        end
        @(negedge Clk);
        fAddr = fA; dReadWrite = dWr; dAddr = dA; dDataIn = dD; dDataSize = dSz;
        fReq = fOn; dReq = dOn;
        lat = 0;
        k = 0;
        while ((fReq || dReq) && k < 100) begin
            @(negedge Clk);
            k++;
            if ((fDone || dDone) && lat == 0) lat = k;
            if (fDone) fReq = 1'b0;
            if (dDone) dReq = 1'b0;
        end
        #1;
        checkValue("roundCompleted", {30'b0, fReq, dReq}, 32'd0);
        if (fReq || dReq) begin
            fReq = 1'b0;
            dReq = 1'b0;
            expQ.delete();
        end
        checkValue("queueDrained", expQ.size(), 32'd0);
    endtask

    initial begin
        int lat;
        int k;
        for (int i = 0; i < 512; i++) begin
            ramMem[i] = 8'($urandom);
            refMem[i] = ramMem[i];
        end
        refF = '0; refD = '0; refLastData = 1'b0;

        nReset = 1'b0;
        repeat (3) @(negedge Clk);
        checkValue("rstActive",   {31'b0, memFuncActive}, 32'd0);
        checkValue("rstReadWrite", {31'b0, readWrite}, 32'd0);
        checkValue("rstAddress",  {23'b0, address}, 32'd0);
        checkValue("rstDataIn",   dataIn, 32'd0);
        checkValue("rstDataSize", {30'b0, dataSize}, 32'd0);
        checkValue("rstDoneErr",  {28'b0, fDone, fErr, dDone, dErr}, 32'd0);
        checkValue("rstFData",    fData, 32'd0);
        checkValue("rstDData",    dData, 32'd0);
        nReset = 1'b1;
        @(negedge Clk);
        monOn = 1'b1;

        // Tie right after reset: data write wins, fetch then reads the new word.
        ramDelay = 3;
        runRound(1'b1, 9'd0, 1'b1, 1'b1, 9'd0, 32'hAABBCCDD, 2'b11, lat);
        checkValue("fetchAfterDataWrite", fData, 32'hAABBCCDD);
        runRound(1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 32'd0, 2'b11, lat);
        checkValue("readBackWord", dData, 32'hAABBCCDD);

        // Misaligned halfword: Err one cycle after grant, no RAM access.
        runRound(1'b0, 9'd0, 1'b1, 1'b0, 9'd5, 32'd0, 2'b01, lat);
        checkValue("badLatency", lat, 32'd2);

        for (int r = 0; r < 80; r++) begin
            bit         fOn, dOn, dWr;
            logic [8:0] fA, dA;
            logic [1:0] sz;
            fOn = ($urandom % 4) != 0;
            dOn = ($urandom % 4) != 0;
            if (!fOn && !dOn) dOn = 1'b1;
            fA = (($urandom % 8) == 0) ? 9'($urandom) : 9'(($urandom % 128) * 4);
            case ($urandom % 8)
                0:       sz = 2'b10;
                1, 2:    sz = 2'b00;
                3, 4:    sz = 2'b01;
                default: sz = 2'b11;
            endcase
            if (($urandom % 6) == 0) begin
                dA = 9'($urandom);
            end else begin
                dA = 9'(($urandom % 128) * 4);
                if (sz == 2'b00) dA[1:0] = 2'($urandom);
                if (sz == 2'b01) dA[1]   = 1'($urandom);
            end
            dWr = 1'($urandom);
            ramDelay = $urandom_range(0, 3);
            runRound(fOn, fA, dOn, dWr, dA, $urandom, sz, lat);
        end
        monOn = 1'b0;
        @(negedge Clk);

`ifdef MEM_ARBITER_TIMEOUT_EN
        // RAM never completes: abort TIMEOUT cycles after ACCESS entry.
        ramHang = 1'b1;
        dReadWrite = 1'b0; dAddr = 9'd8; dDataSize = 2'b11; dReq = 1'b1;
        k = 0;
        while (!memFuncActive && k < 20) begin @(negedge Clk); k++; end
        k = 0;
        while (!dDone && k < 40) begin @(negedge Clk); k++; end
        checkValue("timeoutCycles", k, TO);
        checkValue("timeoutErr", {31'b0, dErr}, 32'd1);
        checkValue("timeoutActiveDropped", {31'b0, memFuncActive}, 32'd0);
        checkValue("timeoutNoCapture", dData, refD);
        dReq = 1'b0;
        ramHang = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
`endif

        // Reset during ACCESS aborts; the held request is served afterwards.
        ramHang = 1'b1;
        dReadWrite = 1'b0; dAddr = 9'd4; dDataSize = 2'b11; dReq = 1'b1;
        k = 0;
        while (!memFuncActive && k < 20) begin @(negedge Clk); k++; end
        checkValue("preResetActive", {31'b0, memFuncActive}, 32'd1);
        #2;
        nReset = 1'b0;
        #1;
        checkValue("rstAbortActive", {31'b0, memFuncActive}, 32'd0);
        checkValue("rstAbortDone", {30'b0, fDone, dDone}, 32'd0);
        checkValue("rstAbortData", dData, 32'd0);
        @(negedge Clk);
        ramHang = 1'b0;
        @(negedge Clk);
        nReset = 1'b1;
        k = 0;
        while (!dDone && k < 40) begin @(negedge Clk); k++; end
        checkValue("reServeDone", {31'b0, dDone}, 32'd1);
        checkValue("reServeErr", {31'b0, dErr}, 32'd0);
        checkValue("reServeData", dData, refWord(9'd4));
        checkValue("reServeFData", fData, 32'd0);
        dReq = 1'b0;
        repeat (3) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: cycles allowed per RAM access before abort (range 2..255).
REQ-002 Clk  input  1  system clock, all state on rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 fReq, fAddr  input  1, 9  fetch port request and byte address; fetch is always a word read.
REQ-005 fDone, fErr, fData  output  1, 1, 32  fetch completion pulse, error flag, read data.
REQ-006 dReq, dReadWrite, dAddr  input  1, 1, 9  data port request, 1=write 0=read, byte address.
REQ-007 dDataIn, dDataSize  input  32, 2  data port write data and size: 00 byte, 01 halfword, 11 word, 10 reserved.
REQ-008 dDone, dErr, dData  output  1, 1, 32  data port completion pulse, error flag, read data.
REQ-009 memFuncActive, readWrite, address, dataIn, dataSize  output  1, 1, 9, 32, 2  RAM-side request bus.
REQ-010 dataOut, memFuncComplete  input  32, 1  RAM read data and completion.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS, RELEASE.
REQ-012 IDLE: on a rising edge with any valid request pending, the arbiter SHALL latch the winner's fields onto the RAM bus, set memFuncActive=1, and enter ACCESS.
REQ-013 Tie (fReq and dReq both high): the port not granted last SHALL win; a lone requester always wins.
REQ-014 ACCESS: on the first edge sampling memFuncComplete=1, a read SHALL capture dataOut into the winner's fData/dData, memFuncActive SHALL go 0, and the state SHALL become RELEASE.
REQ-015 RELEASE: on the first edge sampling memFuncComplete=0, the winner's Done SHALL pulse high for exactly one cycle, with Err=0, and the state SHALL return to IDLE.
REQ-016 RAM-bus fields SHALL stay stable from memFuncActive rise until RELEASE exit.
REQ-017 Requesters SHALL hold Req and fields stable until Done; Req still high on the edge after Done SHALL be a new request.
REQ-018 A request arriving while not IDLE SHALL wait; it SHALL NOT be dropped.
REQ-019 Alignment: word requires addr[1:0]=00, halfword addr[0]=0; misaligned or dataSize=10 requests SHALL win arbitration normally, issue no RAM access, and pulse Done with Err=1 one cycle after grant.
REQ-020 fData/dData SHALL hold their last value except on a completed read for that port; writes leave them unchanged.
REQ-021 Err SHALL be valid only while the matching Done is high and 0 otherwise.

Reset
REQ-022 nReset low SHALL immediately force state IDLE, memFuncActive=0, readWrite=0, address=0, dataIn=0, dataSize=0, all Done/Err=0, fData=dData=0.
REQ-023 After reset the last-grant pointer SHALL equal fetch, so the first tie grants the data port.
REQ-024 Reset mid-access SHALL abort with no Done pulse; the interrupted request, if still held, is re-arbitrated after release.

Configuration
REQ-025 Macro MEM_ARBITER_TIMEOUT_EN defined: a counter SHALL run in ACCESS and RELEASE; reaching TIMEOUT_CYCLES SHALL force memFuncActive=0, capture no data, pulse the winner's Done with Err=1, and return to IDLE.
REQ-026 Macro undefined: no counter is built; the FSM waits indefinitely for memFuncComplete.

Verification
REQ-027 Data write word 32'hAABBCCDD at address 0 with RAM model MFC after 3 cycles -> RAM bus carries readWrite=1, dataSize=11; dDone one pulse, dErr=0.
REQ-028 Data read word at address 0 -> dData=32'hAABBCCDD at dDone; fData unchanged.
REQ-029 fReq and dReq raised on the same edge after reset and held -> data granted first, fetch second, then alternating while both are held.
REQ-030 Halfword read at address 5 -> no memFuncActive rise; dDone with dErr=1 one cycle after grant.
REQ-031 Macro defined, TIMEOUT_CYCLES=8, RAM never asserts MFC -> memFuncActive drops and Done+Err pulses 8 cycles after ACCESS entry.
REQ-032 nReset pulsed low during ACCESS -> memFuncActive=0 immediately, no Done, and the held request is re-served after release.
